// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with press/release debounce, feeding an 8-digit
// BCD entry register (newest digit in [3:0]) with clear, backspace and enter.
module keypad_bcd_entry #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [31:0] value,
    output logic [3:0]  digit_count,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        enter,
    output logic        full
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t        state, next_state;
    logic [3:0]    sync1, srow;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] db_cnt;
    logic [1:0]    col_idx, row_idx, low_row;
    logic [3:0]    row_mask, code;
    logic          scan_done, db_done, any_low, accept, col_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 4'hF;
            srow  <= 4'hF;
        end else begin
            sync1 <= row;
            srow  <= sync1;
        end
    end

    assign scan_done = (scan_cnt == SCAN_LAST);
    assign db_done   = (db_cnt == DB_LAST);
    assign any_low   = (srow != 4'hF);
    assign row_mask  = ~(4'b0001 << row_idx);

    // Lowest-index low row wins when several keys share the driven column.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!srow[i]) low_row = 2'(i);
    end

    always_comb begin
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SCAN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SCAN:     if (scan_done && any_low) next_state = PRESS_DB;
            PRESS_DB: if (srow != row_mask)     next_state = SCAN;
                      else if (db_done)         next_state = HELD;
            HELD:     if (!any_low)             next_state = REL_DB;
            REL_DB:   if (any_low)              next_state = HELD;
                      else if (db_done)         next_state = SCAN;
            default:                            next_state = SCAN;
        endcase
    end

    always_comb begin
        col     = ~(4'b0001 << col_idx);
        full    = (digit_count == 4'd8);
        accept  = (state == PRESS_DB) && (next_state == HELD);
        col_adv = ((state == SCAN) && scan_done && !any_low) ||
                  ((state != SCAN) && (next_state == SCAN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            db_cnt   <= '0;
            col_idx  <= 2'd0;
            row_idx  <= 2'd0;
        end else begin
            scan_cnt <= ((state == SCAN) && !scan_done) ? scan_cnt + 1'b1 : '0;
            // Count only while staying in a debounce state; any exit restarts it.
            if (((state == PRESS_DB) || (state == REL_DB)) && (next_state == state))
                db_cnt <= db_cnt + 1'b1;
            else
                db_cnt <= '0;
            if (col_adv) col_idx <= col_idx + 2'd1;
            if ((state == SCAN) && scan_done && any_low) row_idx <= low_row;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value       <= '0;
            digit_count <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            enter       <= 1'b0;
        end else begin
            key_valid <= accept;
            enter     <= accept && (code == 4'hD);
            if (accept) begin
                key_code <= code;
                if (code <= 4'h9) begin
                    if (digit_count < 4'd8) begin
                        value       <= {value[27:0], code};
                        digit_count <= digit_count + 4'd1;
                    end
                end else if (code == 4'hE) begin
                    value       <= '0;
                    digit_count <= '0;
                end else if (code == 4'hF) begin
                    value <= {4'h0, value[31:4]};
                    if (digit_count != 4'd0) digit_count <= digit_count - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry: a behavioural keypad matrix drives rows
// from the scanned column, with optional press/release bounce injection.
module tb_keypad_bcd_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row, col, digit_count, key_code;
    logic [31:0] value;
    logic        key_valid, enter, full;

    logic [15:0] keys = '0;
    logic        bounce_press = 1'b0, bounce_rel = 1'b0;
    logic [1:0]  bph = 2'd0;
    int          checks = 0, failures = 0, kv_cnt = 0, ent_cnt = 0;

    keypad_bcd_entry #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .value(value),
        .digit_count(digit_count), .key_valid(key_valid), .key_code(key_code),
        .enter(enter), .full(full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bph <= bph + 2'd1;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
        if (bounce_press && bph == 2'd3) row = 4'hF;
        if (bounce_rel && bph != 2'd0)   row = 4'hF;
    end

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (enter)     ent_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_kv(input string tag, input int target);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #1;
            if (kv_cnt >= target) break;
        end
        chk(tag, kv_cnt, target);
    endtask

    task automatic press(input string tag, input int r, input int c);
        int target;
        target = kv_cnt + 1;
        keys[r*4+c] = 1'b1;
        wait_kv(tag, target);
        keys = '0;
        repeat (20) @(negedge clk);
        #1;
        chk({tag, "_single"}, kv_cnt, target);
    endtask

    task automatic wait_col(input logic [3:0] want);
        int n;
        n = 0;
        while (col !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_col", col, want);
    endtask

    initial begin
        logic [3:0] seq [12];
        int base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_value", value, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_col", col, 4'b1110);
        chk("rst_flags", {key_valid, enter, full, key_code}, 0);
        rst = 1'b0;

        // Idle scan: each column driven for 4 clocks in order
        seq = '{4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
                4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
        wait_col(4'b1101);
        for (int k = 0; k < 12; k++) begin
            chk("scan_col", col, seq[k]);
            @(negedge clk);
        end
        chk("idle_no_kv", kv_cnt, 0);

        press("key1", 0, 0);
        press("key2", 0, 1);
        press("key3", 0, 2);
        chk("val_123", value, 32'h123);
        chk("cnt_3", digit_count, 3);
        press("bksp", 3, 2);
        chk("val_12", value, 32'h12);
        chk("cnt_2", digit_count, 2);
        press("clear", 3, 0);
        chk("val_clr", value, 0);
        chk("cnt_clr", digit_count, 0);
        press("bksp0", 3, 2);
        chk("bksp_sat", {value[3:0], digit_count}, 0);
        press("key4", 1, 0);
        press("keyD", 3, 3);
        chk("enter_cnt", ent_cnt, 1);
        chk("code_D", key_code, 4'hD);
        chk("val_after_D", value, 32'h4);
        press("keyA", 0, 3);
        chk("code_A", key_code, 4'hA);
        chk("val_after_A", value, 32'h4);
        chk("enter_cnt_A", ent_cnt, 1);
        press("clear2", 3, 0);

        for (int k = 0; k < 8; k++) press("key9", 2, 2);
        chk("val_full", value, 32'h99999999);
        chk("cnt_8", digit_count, 8);
        chk("full_8", full, 1);
        press("key9_over", 2, 2);
        chk("code_9", key_code, 4'h9);
        chk("val_over", value, 32'h99999999);
        chk("cnt_over", digit_count, 8);
        press("bksp_full", 3, 2);
        chk("val_bk", value, 32'h09999999);
        chk("full_7", {digit_count, full}, {4'd7, 1'b0});
        press("clear3", 3, 0);

        // Press bounce: one high cycle in every four keeps PRESS_DB from finishing
        base = kv_cnt;
        bounce_press = 1'b1;
        keys[1*4+1] = 1'b1;
        repeat (200) @(negedge clk);
        keys = '0;
        bounce_press = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("bounce_press_kv", kv_cnt, base);

        // Release bounce: key accepted once, bouncing release must not repeat it
        keys[1*4+1] = 1'b1;
        wait_kv("rel_press", base + 1);
        bounce_rel = 1'b1;
        repeat (60) @(negedge clk);
        keys = '0;
        bounce_rel = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("bounce_rel_kv", kv_cnt, base + 1);
        chk("val_5", value, 32'h5);

        // Reset in the middle of a press debounce with the key still held
        base = kv_cnt;
        wait_col(4'b0111);
        keys[2*4+0] = 1'b1;
        wait_col(4'b1110);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_value", value, 0);
        chk("mid_rst_count", digit_count, 0);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_col", col, 4'b1110);
        chk("mid_rst_kv", kv_cnt, base);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_kv("post_rst", base + 1);
        keys = '0;
        repeat (30) @(negedge clk);
        #1;
        chk("post_rst_single", kv_cnt, base + 1);
        chk("post_rst_code", key_code, 4'h7);
        chk("post_rst_val", {value, digit_count}, {32'h7, 4'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_bcd_entry.md
Name: keypad_bcd_entry

Overview:
- Scans a 4x4 matrix keypad, debounces press and release, and decodes each accepted key.
- Accumulates up to 8 BCD digits into a 32-bit value with the same packing the seven-segment path displays: digit 0 in [3:0], newest digit lowest.
- Sits on the input side of the board, feeding operand values to downstream logic and to the display driver.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before rows are sampled (>=4).
- DEBOUNCE_CYC, 100000: consecutive stable cycles required to accept a press or a release (>=2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col  output  4  keypad column drive, one-hot active-low
- value  output  32  entered BCD digits, digit 0 in [3:0]
- digit_count  output  4  number of valid digits in value, 0..8
- key_valid  output  1  one-cycle pulse per accepted key
- key_code  output  4  code of last accepted key
- enter  output  1  one-cycle pulse when the D key is accepted
- full  output  1  high while digit_count==8

Behaviour:
- Reset values:
  - value=0, digit_count=0, key_valid=0, key_code=0, enter=0, full=0.
  - col=4'b1110 (column 0), state=SCAN, all counters 0.
- Row synchronisation:
  - row passes through a 2-flop synchronizer; only the synchronized rows (srow) are used.
- Key map, row r / col c, codes 0-9 equal the digit value:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *=E, 0, #=F, D
  - A=0xA, B=0xB, C=0xC, D=0xD.
- FSM states:
  - SCAN:
    - Drive the current column and count SCAN_DIV cycles.
    - On the terminal cycle, if srow==4'hF, advance to the next column (3 wraps to 0).
    - Otherwise latch the column and the lowest-index low row, then go to PRESS_DB.
  - PRESS_DB:
    - Hold the column and count cycles while srow shows exactly the latched row low.
    - Any other srow pattern aborts to SCAN with the next column; no key is emitted.
    - Reaching DEBOUNCE_CYC goes to HELD and performs the key action.
  - HELD:
    - Hold the column; wait for srow==4'hF, then go to REL_DB.
  - REL_DB:
    - Count consecutive cycles with srow==4'hF; any low row returns to HELD.
    - Reaching DEBOUNCE_CYC goes to SCAN with the next column.
- Key action, registered on the PRESS_DB->HELD transition edge:
  - key_valid=1 for exactly that cycle; key_code updates on the same edge.
  - Digit key with digit_count<8: value<={value[27:0],digit} and digit_count+1.
  - Digit key with digit_count==8: key_valid still pulses; value and count are unchanged.
  - * (clear): value=0, digit_count=0.
  - # (backspace): value<={4'h0,value[31:4]} and digit_count-1, saturating at 0.
  - D: enter=1 for the same single cycle; value is unchanged.
  - A, B, C: key_valid and key_code only.
  - full is combinational from digit_count (digit_count==8).
- Simultaneous keys:
  - Two keys in one column: the lowest row wins at the sample point.
  - A second row going low during PRESS_DB aborts the press.
  - Keys held in HELD do not repeat; exactly one key_valid per press.
- Latency:
  - First key_valid is at most 4*SCAN_DIV + DEBOUNCE_CYC + 3 cycles after a stable press.
- Reset is asynchronous at any point, including mid-debounce: all outputs return to reset values immediately, and a still-held key is reaccepted only after a full SCAN and PRESS_DB cycle.
- Widths: debounce counter is clog2(DEBOUNCE_CYC+1) bits; scan counter is clog2(SCAN_DIV) bits.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8):
- Reset, no key -> col cycles 1110,1101,1011,0111 every 4 clocks; value=0, key_valid never set.
- Press 1,2,3 with clean press/release -> three key_valid pulses; value=32'h00000123, digit_count=3.
- Press 9 nine times -> value=32'h99999999, full=1 after the 8th; the 9th gives key_valid=1 and value unchanged.
- From value=0x123: press #, then * -> value=0x12 with count 2, then value=0 with count 0; press D -> enter pulse, key_code=0xD, value unchanged.
- Bounce: row low 3 cycles, high 1 cycle, repeated during PRESS_DB -> no key_valid. Release bounce on a held key -> single key_valid total.
- Assert rst mid-PRESS_DB with key held -> outputs at reset values at once; after release of rst the held key produces exactly one key_valid.
